// File: rtl/blit_addrclip.sv
// blit_addrclip: per-channel pixel address clip test with a two-stage
// valid/ready pipeline and saturating per-channel clip statistics.
//
// Stage 1 registers the per-axis compare flags for every channel, stage 2
// registers their OR as the clip result. Both stages advance together
// whenever the output register is empty or being drained.
//
// Optional feature macro: ADDRCLIP_MINWIN_EN adds a lower window bound
// (winmin_x / winmin_y). When it is undefined, the lower bound is the sign bit only.
//
// Ports:
//   sys_clk              clock, rising edge
//   reset                asynchronous active-high reset
//   in_valid / in_ready  input handshake
//   addr_x / addr_y      CH*AW, channel c at [c*AW +: AW], bit AW-1 = sign
//   win_x / win_y        CH*(AW-1), exclusive upper bound per channel
//   winmin_x / winmin_y  CH*(AW-1), inclusive lower bound (ADDRCLIP_MINWIN_EN only)
//   out_valid/out_ready  output handshake
//   outside              CH, per-channel clip result
//   clip_cnt             CH*CW, saturating count of clipped results per channel
//   any_clip             sticky flag: any channel clipped since the last clear
//   clr                  synchronous clear of clip_cnt and any_clip
module blit_addrclip #(
    parameter int unsigned AW = 16,
    parameter int unsigned CH = 2,
    parameter int unsigned CW = 16
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*AW-1:0]     addr_x,
    input  logic [CH*AW-1:0]     addr_y,
    input  logic [CH*(AW-1)-1:0] win_x,
    input  logic [CH*(AW-1)-1:0] win_y,
`ifdef ADDRCLIP_MINWIN_EN
    input  logic [CH*(AW-1)-1:0] winmin_x,
    input  logic [CH*(AW-1)-1:0] winmin_y,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH-1:0]        outside,
    output logic [CH*CW-1:0]     clip_cnt,
    output logic                 any_clip,
    input  logic                 clr
);

    localparam int unsigned MW = AW - 1;
`ifdef ADDRCLIP_MINWIN_EN
    localparam int unsigned NF = 6;
`else
    localparam int unsigned NF = 4;
`endif

    logic             advance;
    logic             s1_valid;
    logic [CH*NF-1:0] flags_d;
    logic [CH*NF-1:0] s1_flags;
    logic [CH-1:0]    outside_d;

    // The whole pipeline moves as one unit; a held output freezes stage 1 too.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Per-axis compare flags; equality with the window size counts as outside.
    always_comb begin
        flags_d = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            flags_d[c*NF + 0] = addr_x[c*AW + MW];
            flags_d[c*NF + 1] = addr_x[c*AW +: MW] >= win_x[c*MW +: MW];
            flags_d[c*NF + 2] = addr_y[c*AW + MW];
            flags_d[c*NF + 3] = addr_y[c*AW +: MW] >= win_y[c*MW +: MW];
`ifdef ADDRCLIP_MINWIN_EN
            flags_d[c*NF + 4] = addr_x[c*AW +: MW] < winmin_x[c*MW +: MW];
            flags_d[c*NF + 5] = addr_y[c*AW +: MW] < winmin_y[c*MW +: MW];
`endif
        end
    end

    always_comb begin
        outside_d = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            outside_d[c] = |s1_flags[c*NF +: NF];
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_flags  <= '0;
            out_valid <= 1'b0;
            outside   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_flags  <= flags_d;
            out_valid <= s1_valid;
            // A bubble leaves outside at zero so stale flags never surface.
            outside   <= s1_valid ? outside_d : '0;
        end
    end

    // Statistics count only on output handshakes; clr takes priority over
    // a coincident counting handshake.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            clip_cnt <= '0;
            any_clip <= 1'b0;
        end else if (clr) begin
            clip_cnt <= '0;
            any_clip <= 1'b0;
        end else if (out_valid && out_ready) begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (outside[c] && (clip_cnt[c*CW +: CW] != '1)) begin
                    clip_cnt[c*CW +: CW] <= clip_cnt[c*CW +: CW] + CW'(1);
                end
            end
            if (|outside) begin
                any_clip <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blit_addrclip.sv
// tb_blit_addrclip: self-checking bench for blit_addrclip (AW=16, CH=2, CW=4).
// A queue-based reference model computes each clip result from the window
// rules at input acceptance and tracks the saturating statistics.
`timescale 1ns/1ps
module tb_blit_addrclip;

    localparam int unsigned AW = 16;
    localparam int unsigned CH = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned WW = AW - 1;
    localparam int MAXC = (1 << CW) - 1;
    localparam int HALF = 1 << (AW - 1);

    logic             sys_clk   = 1'b0;
    logic             reset     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [CH*AW-1:0] addr_x    = '0;
    logic [CH*AW-1:0] addr_y    = '0;
    logic [CH*WW-1:0] win_x     = '0;
    logic [CH*WW-1:0] win_y     = '0;
`ifdef ADDRCLIP_MINWIN_EN
    logic [CH*WW-1:0] winmin_x  = '0;
    logic [CH*WW-1:0] winmin_y  = '0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CH-1:0]    outside;
    logic [CH*CW-1:0] clip_cnt;
    logic             any_clip;
    logic             clr       = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit            hi;
        bit            ho;
        bit            ir;
        bit            ov;
        bit            ordy;
        bit            under;
        logic [CH-1:0] exp;
        logic [CH-1:0] obs;
        int            lat;
    } smp_t;

    logic [CH-1:0] exp_q[$];
    int            acc_q[$];
    int            cnt_m[CH];
    bit            any_m;

    always #5 sys_clk = ~sys_clk;

    blit_addrclip #(.AW(AW), .CH(CH), .CW(CW)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .win_x    (win_x),
        .win_y    (win_y),
`ifdef ADDRCLIP_MINWIN_EN
        .winmin_x (winmin_x),
        .winmin_y (winmin_y),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outside  (outside),
        .clip_cnt (clip_cnt),
        .any_clip (any_clip),
        .clr      (clr)
    );

    // Reference clip rule: negative, or magnitude at/above the window size.
    function automatic logic [CH-1:0] ref_out(input logic [CH*AW-1:0] x, input logic [CH*AW-1:0] y);
        logic [CH-1:0] r;
        int xv, yv, mx, my;
        for (int c = 0; c < CH; c++) begin
            xv = int'(x[c*AW +: AW]);
            yv = int'(y[c*AW +: AW]);
            mx = xv % HALF;
            my = yv % HALF;
            r[c] = (xv >= HALF) || (mx >= int'(win_x[c*WW +: WW])) ||
                   (yv >= HALF) || (my >= int'(win_y[c*WW +: WW]));
`ifdef ADDRCLIP_MINWIN_EN
            r[c] = r[c] || (mx < int'(winmin_x[c*WW +: WW])) || (my < int'(winmin_y[c*WW +: WW]));
`endif
        end
        return r;
    endfunction

    function automatic logic [CH*CW-1:0] model_cnt();
        logic [CH*CW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*CW +: CW] = CW'(cnt_m[c]);
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_comp(input int w);
        logic [AW-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = AW'(w - 1);
            1:       v = AW'(w);
            2:       v = AW'(w + 1);
            3:       v = AW'($urandom);
            4:       v = AW'($urandom_range(0, w));
            default: v = {1'b1, WW'($urandom)};
        endcase
        return v;
    endfunction

    function automatic logic [CH*AW-1:0] rand_addr(input logic [CH*WW-1:0] w);
        logic [CH*AW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*AW +: AW] = rand_comp(int'(w[c*WW +: WW]));
        return r;
    endfunction

    // One clock of observation: sample handshakes mid-cycle, advance the model,
    // then return just after the next rising edge.
    task automatic step(output smp_t s);
        @(negedge sys_clk);
        s.hi    = in_valid && in_ready;
        s.ho    = out_valid && out_ready;
        s.ir    = in_ready;
        s.ov    = out_valid;
        s.ordy  = out_ready;
        s.obs   = outside;
        s.under = 1'b0;
        s.exp   = '0;
        s.lat   = 0;
        if (s.ho) begin
            if (exp_q.size() == 0) s.under = 1'b1;
            else begin
                s.exp = exp_q.pop_front();
                s.lat = cyc - acc_q.pop_front();
            end
        end
        if (clr) begin
            cnt_m = '{default: 0};
            any_m = 1'b0;
        end else if (s.ho && !s.under) begin
            for (int c = 0; c < CH; c++) if (s.exp[c] && cnt_m[c] < MAXC) cnt_m[c]++;
            if (|s.exp) any_m = 1'b1;
        end
        if (s.hi) begin
            exp_q.push_back(ref_out(addr_x, addr_y));
            acc_q.push_back(cyc);
        end
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (outside !== '0) begin errors++; $display("FAIL rst_outside: got %b exp 0", outside); end
        checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL rst_clip_cnt: got %h exp 0", clip_cnt); end
        checks++; if (any_clip !== 1'b0) begin errors++; $display("FAIL rst_any_clip: got %b exp 0", any_clip); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_boundary();
        smp_t s;
        logic [CH-1:0] want[2];
        int outs = 0;
        want[0] = 2'b10;
        want[1] = 2'b01;
        out_ready = 1'b1;
        // ch0 (319,199) inside, ch1 (320,0) outside
        in_valid = 1'b1; addr_x = {16'd320, 16'd319}; addr_y = {16'd0, 16'd199};
        step(s);
        // ch0 (5,0xFFFF) outside, ch1 (319,199) inside
        addr_x = {16'd319, 16'd5}; addr_y = {16'd199, 16'hFFFF};
        step(s);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(s);
            if (s.ho) begin
                if (outs < 2) begin
                    checks++;
                    if (s.obs !== want[outs]) begin errors++; $display("FAIL bound_outside[%0d]: got %b exp %b", outs, s.obs, want[outs]); end
                    checks++;
                    if (s.lat != 2) begin errors++; $display("FAIL bound_latency[%0d]: got %0d exp 2", outs, s.lat); end
                end
                outs++;
            end
        end
        checks++; if (outs != 2) begin errors++; $display("FAIL bound_count: got %0d exp 2", outs); end
    endtask

    task automatic test_back_to_back();
        smp_t s;
        int sent = 0, outs = 0, first = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = (sent < 8);
            if (sent < 8) begin addr_x = rand_addr(win_x); addr_y = rand_addr(win_y); end
            step(s);
            if (s.hi) sent++;
            if (s.ho) begin
                if (first < 0) first = cyc;
                checks++;
                if (s.under || s.obs !== s.exp) begin errors++; $display("FAIL b2b_outside[%0d]: got %b exp %b under=%0d", outs, s.obs, s.exp, s.under); end
                checks++;
                if (s.lat != 2) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d exp 2", outs, s.lat); end
                checks++;
                if (cyc - first != outs) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d exp %0d", outs, cyc - first, outs); end
                outs++;
            end
            if (sent == 8 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        checks++; if (outs != 8) begin errors++; $display("FAIL b2b_count: got %0d exp 8", outs); end
    endtask

    task automatic test_stall();
        smp_t s;
        logic [CH*AW-1:0] px[10], py[10];
        int ptr = 0, outs = 0, stall_n = 0;
        bit prev_stall = 1'b0;
        logic [CH-1:0] prev_obs = '0;
        for (int i = 0; i < 10; i++) begin px[i] = rand_addr(win_x); py[i] = rand_addr(win_y); end
        for (int k = 0; k < 40; k++) begin
            in_valid = (ptr < 10);
            if (ptr < 10) begin addr_x = px[ptr]; addr_y = py[ptr]; end
            out_ready = !(k >= 3 && k <= 5);
            step(s);
            if (s.hi) ptr++;
            if (s.ho) begin
                outs++;
                checks++;
                if (s.under || s.obs !== s.exp) begin errors++; $display("FAIL stall_outside[%0d]: got %b exp %b under=%0d", outs, s.obs, s.exp, s.under); end
            end
            if (s.ov && !s.ordy) begin
                stall_n++;
                checks++;
                if (s.ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b exp 0", s.ir); end
                if (prev_stall) begin
                    checks++;
                    if (s.obs !== prev_obs) begin errors++; $display("FAIL stall_hold: got %b exp %b", s.obs, prev_obs); end
                end
            end
            prev_stall = s.ov && !s.ordy;
            prev_obs = s.obs;
            if (ptr == 10 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (stall_n != 3) begin errors++; $display("FAIL stall_cycles: got %0d exp 3", stall_n); end
        checks++; if (outs != 10) begin errors++; $display("FAIL stall_count: got %0d exp 10", outs); end
    endtask

    task automatic test_sat_clr();
        smp_t s;
        int sent = 0;
        out_ready = 1'b1;
        clr = 1'b1; step(s); clr = 1'b0;
        // ch0 negative x (clips), ch1 (10,10) inside
        addr_x = {16'd10, 16'h8000}; addr_y = {16'd10, 16'd10};
        for (int k = 0; k < 60; k++) begin
            in_valid = (sent < 22);
            step(s);
            if (s.hi) sent++;
            if (s.ho) begin
                checks++;
                if (s.under || s.obs !== s.exp) begin errors++; $display("FAIL sat_outside: got %b exp %b", s.obs, s.exp); end
            end
            if (sent == 22 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        checks++; if (clip_cnt[3:0] !== 4'd15) begin errors++; $display("FAIL sat_cnt0: got %0d exp 15", clip_cnt[3:0]); end
        checks++; if (clip_cnt[7:4] !== 4'd0) begin errors++; $display("FAIL sat_cnt1: got %0d exp 0", clip_cnt[7:4]); end
        checks++; if (any_clip !== 1'b1) begin errors++; $display("FAIL sat_any: got %b exp 1", any_clip); end
        // One more clipped result, with clr landing on its output handshake.
        in_valid = 1'b1; step(s); in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) break;
            step(s);
        end
        clr = 1'b1;
        step(s);
        clr = 1'b0;
        checks++; if (!s.ho) begin errors++; $display("FAIL clr_handshake: got %b exp 1", s.ho); end
        checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL clr_cnt: got %h exp 0", clip_cnt); end
        checks++; if (any_clip !== 1'b0) begin errors++; $display("FAIL clr_any: got %b exp 0", any_clip); end
    endtask

    task automatic test_reset_inflight();
        smp_t s;
        out_ready = 1'b1;
        addr_x = {16'd10, 16'h8000}; addr_y = {16'd10, 16'd10};
        in_valid = 1'b1; step(s); in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step(s);
        checks++; if (clip_cnt !== model_cnt() || clip_cnt === '0) begin errors++; $display("FAIL pre_cnt: got %h exp %h", clip_cnt, model_cnt()); end
        in_valid = 1'b1; step(s); step(s); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b exp 1", out_valid); end
        reset = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        cnt_m = '{default: 0};
        any_m = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst2_out_valid: got %b exp 0", out_valid); end
        checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL rst2_cnt: got %h exp 0", clip_cnt); end
        checks++; if (any_clip !== 1'b0) begin errors++; $display("FAIL rst2_any: got %b exp 0", any_clip); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst2_in_ready: got %b exp 1", in_ready); end
        @(posedge sys_clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(s);
            checks++;
            if (s.ov !== 1'b0) begin errors++; $display("FAIL rst2_stale[%0d]: got %b exp 0", k, s.ov); end
        end
        checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL rst2_cnt_after: got %h exp 0", clip_cnt); end
    endtask

    task automatic test_random();
        smp_t s;
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) begin
                for (int c = 0; c < CH; c++) begin
                    win_x[c*WW +: WW] = WW'($urandom_range(0, 400));
                    win_y[c*WW +: WW] = WW'($urandom_range(0, 400));
                end
            end
            addr_x = rand_addr(win_x);
            addr_y = rand_addr(win_y);
            step(s);
            checks++;
            if (s.ir !== (!s.ov || s.ordy)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b ov=%b ordy=%b", k, s.ir, s.ov, s.ordy); end
            if (s.ho) begin
                checks++;
                if (s.under || s.obs !== s.exp) begin errors++; $display("FAIL rnd_outside[%0d]: got %b exp %b under=%0d", k, s.obs, s.exp, s.under); end
            end
            checks++;
            if (clip_cnt !== model_cnt() || any_clip !== any_m) begin
                errors++; $display("FAIL rnd_stats[%0d]: got cnt=%h any=%b exp cnt=%h any=%b", k, clip_cnt, any_clip, model_cnt(), any_m);
            end
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(s);
            if (s.ho) begin
                checks++;
                if (s.under || s.obs !== s.exp) begin errors++; $display("FAIL rnd_drain: got %b exp %b", s.obs, s.exp); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d pending exp 0", exp_q.size()); end
    endtask

`ifdef ADDRCLIP_MINWIN_EN
    task automatic test_minwin();
        smp_t s;
        int outs = 0;
        win_x = {2{15'd320}}; win_y = {2{15'd200}};
        winmin_x = {2{15'd16}}; winmin_y = '0;
        out_ready = 1'b1;
        // ch0 x=15 below minimum, ch1 x=16 on it
        in_valid = 1'b1; addr_x = {16'd16, 16'd15}; addr_y = {16'd50, 16'd50};
        step(s);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(s);
            if (s.ho) begin
                outs++;
                checks++;
                if (s.obs !== 2'b01) begin errors++; $display("FAIL minwin_outside: got %b exp 01", s.obs); end
            end
        end
        checks++; if (outs != 1) begin errors++; $display("FAIL minwin_count: got %0d exp 1", outs); end
        winmin_x = '0;
    endtask
`endif

    initial begin
        cnt_m = '{default: 0};
        any_m = 1'b0;
        win_x = {2{15'd320}};
        win_y = {2{15'd200}};
        test_reset();
        test_boundary();
        test_back_to_back();
        test_stall();
        test_sat_clr();
        test_reset_inflight();
        test_random();
`ifdef ADDRCLIP_MINWIN_EN
        test_minwin();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blit_addrclip.md
BLIT_ADDRCLIP -- requirements
Module: blit_addrclip

Interface
REQ-001 Parameter AW, default 16: address component width; bit AW-1 is the sign bit, bits AW-2..0 are magnitude.
REQ-002 Parameter CH, default 2: number of independent address channels (A1, A2, ...).
REQ-003 Parameter CW, default 16: width of each per-channel clip counter.
REQ-004 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  input address set valid.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 addr_x / addr_y  in  CH*AW each  per-channel pixel X/Y, channel c at bits [c*AW +: AW].
REQ-009 win_x / win_y  in  CH*(AW-1) each  per-channel window width/height, unsigned, quasi-static.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 outside  out  CH  per-channel clip result.
REQ-013 clip_cnt  out  CH*CW  per-channel saturating count of clipped results.
REQ-014 any_clip  out  1  sticky: some channel clipped since last clear.
REQ-015 clr  in  1  synchronous clear of clip_cnt and any_clip.

Function
REQ-016 Channel c outside = sign(x) OR x[AW-2:0] >= win_x OR sign(y) OR y[AW-2:0] >= win_y; compare is unsigned, equality counts as outside.
REQ-017 Two-stage pipeline: stage 1 registers the four per-axis compare flags per channel; stage 2 registers the OR into outside.
REQ-018 Latency exactly 2 cycles from input handshake to out_valid with no stall.
REQ-019 advance = !out_valid OR out_ready; in_ready = advance; both stages move only on advance.
REQ-020 Stage-1 bubbles propagate; an empty stage 2 never asserts out_valid.
REQ-021 While out_valid && !out_ready, outside holds stable and no input is accepted.
REQ-022 Full throughput: one result per cycle when in_valid and out_ready are held high.
REQ-023 On output handshake (out_valid && out_ready), clip_cnt[c] increments by 1 for each c with outside[c]=1.
REQ-024 clip_cnt saturates at 2^CW-1; no wrap-around.
REQ-025 any_clip sets on any output handshake with any outside bit high; stays set until clr or reset.
REQ-026 clr coincident with a counting handshake: clear wins; counters = 0, any_clip = 0 next cycle.
REQ-027 clr does not affect pipeline valids or data.
REQ-028 Window changes take effect for inputs accepted after the change; in-flight results unaffected.

Reset
REQ-029 reset asserted: out_valid=0, stage-1 valid=0, outside=0, clip_cnt=0, any_clip=0, immediately and asynchronously.
REQ-030 Reset mid-operation discards in-flight results; no counter increment for them.
REQ-031 in_ready = 1 while reset is asserted and after release.

Configuration
REQ-032 Macro ADDRCLIP_MINWIN_EN defined: add ports winmin_x / winmin_y (in, CH*(AW-1)); outside additionally set when x[AW-2:0] < winmin_x or y[AW-2:0] < winmin_y; stage 1 holds six flags per channel; latency unchanged.
REQ-033 ADDRCLIP_MINWIN_EN undefined: no winmin ports; lower bound is the sign bit only (REQ-016).

Verification
REQ-034 AW=16, win_x=320, win_y=200; x=319, y=199 -> outside=0 two cycles later; x=320 -> outside=1; y=0xFFFF -> outside=1.
REQ-035 Stream 8 inputs back-to-back with out_ready=1 -> 8 consecutive out_valid cycles starting cycle 2, in order.
REQ-036 out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, outside stable, no loss or duplication.
REQ-037 CW=4, 20 clipped channel-0 results -> clip_cnt[0]=15 held; clr with simultaneous clipped handshake -> clip_cnt=0, any_clip=0.
REQ-038 reset pulse with 2 results in flight -> out_valid=0 at once, counters 0, no stale result after release.
REQ-039 With ADDRCLIP_MINWIN_EN, winmin_x=16: x=15 -> outside=1, x=16 -> outside=0 (win_x=320).
